// File: rtl/iq_modulation_if.sv
// iq_modulation_if: baseband-in / IF-out bundle between the pulse shaper, modulator and DAC path
interface iq_modulation_if #(parameter int W = 5);
  logic tx_en;
  logic bb_rdy;
  logic signed [W-1:0] I_BB;
  logic signed [W-1:0] Q_BB;
  logic signed [W-1:0] I_IF;
  logic signed [W-1:0] Q_IF;
  logic mod_rdy;
  logic signed [1:0] cosine_out;
  logic signed [1:0] sine_out;
  logic busy;
  logic sat_flag;
  modport master (
    output tx_en, bb_rdy, I_BB, Q_BB,
    input I_IF, Q_IF, mod_rdy, cosine_out, sine_out, busy, sat_flag
  );
  modport slave (
    input tx_en, bb_rdy, I_BB, Q_BB,
    output I_IF, Q_IF, mod_rdy, cosine_out, sine_out, busy, sat_flag
  );
endinterface

// File: rtl/iq_modulation.sv
// iq_modulation: rotates signed baseband I/Q up to IF with a quarter-rate {-1,0,+1} carrier
module iq_modulation #(
  parameter int W = 5,
  parameter int PHASE_INIT = 0
) (
  input logic clk,
  input logic resetn,
  iq_modulation_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX = ~MIN;
  localparam logic [1:0] P0 = PHASE_INIT[1:0];
  state_t state;
  logic [1:0] phase, phase_nx;
  logic signed [1:0] cos_c, sin_c;
  logic signed [W-1:0] ni, nq, ri, rq;
  logic neg_sat;
  function automatic logic signed [W-1:0] neg(input logic signed [W-1:0] x);
    return x == MIN ? MAX : -x;
  endfunction
  assign phase_nx = phase + 2'd1;
  assign bus.busy = state != IDLE;
  always_comb begin
    cos_c = phase == 2'd0 ? 2'sd1 : phase == 2'd2 ? -2'sd1 : 2'sd0;
    sin_c = phase == 2'd1 ? 2'sd1 : phase == 2'd3 ? -2'sd1 : 2'sd0;
    ni = neg(bus.I_BB);
    nq = neg(bus.Q_BB);
    ri = phase == 2'd0 ? bus.I_BB : phase == 2'd1 ? nq : phase == 2'd2 ? ni : bus.Q_BB;
    rq = phase == 2'd0 ? bus.Q_BB : phase == 2'd1 ? bus.I_BB : phase == 2'd2 ? nq : ni;
    // I is negated in phases 2,3; Q in phases 1,2
    neg_sat = (phase[1] && bus.I_BB == MIN) || ((phase[1] ^ phase[0]) && bus.Q_BB == MIN);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      phase <= P0;
      bus.I_IF <= '0;
      bus.Q_IF <= '0;
      bus.mod_rdy <= 1'b0;
      bus.cosine_out <= '0;
      bus.sine_out <= '0;
      bus.sat_flag <= 1'b0;
    end else begin
      bus.mod_rdy <= 1'b0;
      if (state != IDLE && bus.bb_rdy) begin
        bus.I_IF <= state == RUN ? ri : '0;
        bus.Q_IF <= state == RUN ? rq : '0;
        bus.cosine_out <= cos_c;
        bus.sine_out <= sin_c;
        bus.mod_rdy <= 1'b1;
        phase <= phase_nx;
        if (state == RUN && neg_sat) bus.sat_flag <= 1'b1;
      end
      // stop decisions look at the phase after any strobe accepted this cycle
      case (state)
        IDLE: if (bus.tx_en) begin
          state <= RUN;
          phase <= P0;
          bus.sat_flag <= 1'b0;
        end
        RUN: if (!bus.tx_en) state <= ((bus.bb_rdy ? phase_nx : phase) != P0) ? FLUSH : IDLE;
        FLUSH: if (bus.tx_en) state <= RUN;
          else if (bus.bb_rdy && phase_nx == P0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iq_modulation.sv
// tb_iq_modulation: scoreboard bench; expected IF samples queued at drive time, popped on mod_rdy
module tb_iq_modulation;
  localparam int PI = 0;
  logic clk = 0;
  logic resetn = 1;
  iq_modulation_if #(.W(5)) bus();
  iq_modulation #(.W(5), .PHASE_INIT(PI)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int i; int q; int c; int s; int due;} exp_t;
  exp_t sb[$];
  exp_t last = '{default: 0};
  exp_t got;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int m_state = 0, m_phase = PI;
  bit m_sat = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic int cos_of(int p);
    return p == 0 ? 1 : p == 2 ? -1 : 0;
  endfunction
  function automatic int sin_of(int p);
    return p == 1 ? 1 : p == 3 ? -1 : 0;
  endfunction
  function automatic int clamp(int v);
    return v > 15 ? 15 : v;
  endfunction
  task automatic push(int i, int q);
    exp_t e;
    e.i = i; e.q = q; e.c = cos_of(m_phase); e.s = sin_of(m_phase); e.due = cyc + 1;
    sb.push_back(e);
  endtask
  task automatic step(bit tx, bit rdy = 0, int i = 0, int q = 0);
    int ri, rq;
    @(negedge clk);
    bus.tx_en = tx; bus.bb_rdy = rdy; bus.I_BB = 5'(i); bus.Q_BB = 5'(q);
    if (m_state == 1 && rdy) begin
      ri = i * cos_of(m_phase) - q * sin_of(m_phase);
      rq = q * cos_of(m_phase) + i * sin_of(m_phase);
      if (ri > 15 || rq > 15) m_sat = 1;
      push(clamp(ri), clamp(rq));
    end else if (m_state == 2 && rdy) push(0, 0);
    if (m_state == 0) begin
      if (tx) begin m_state = 1; m_phase = PI; m_sat = 0; end
    end else begin
      if (rdy) m_phase = (m_phase + 1) % 4;
      if (m_state == 1) begin
        if (!tx) m_state = m_phase != PI ? 2 : 0;
      end else if (tx) m_state = 1;
      else if (rdy && m_phase == PI) m_state = 0;
    end
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_i_if"}, bus.I_IF, 0);
    chk({tag, "_q_if"}, bus.Q_IF, 0);
    chk({tag, "_mod_rdy"}, bus.mod_rdy, 0);
    chk({tag, "_cos"}, bus.cosine_out, 0);
    chk({tag, "_sin"}, bus.sine_out, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_sat"}, bus.sat_flag, 0);
  endtask
  always @(negedge clk) if (resetn) begin
    if (bus.mod_rdy) begin
      if (sb.size() == 0) chk("spurious_mod_rdy", 1, 0);
      else begin
        got = sb.pop_front();
        chk("i_if", bus.I_IF, got.i);
        chk("q_if", bus.Q_IF, got.q);
        chk("cos", bus.cosine_out, got.c);
        chk("sin", bus.sine_out, got.s);
        chk("latency", cyc, got.due);
        last = got;
      end
    end else begin
      chk("hold", int'(bus.I_IF == last.i && bus.Q_IF == last.q &&
                       bus.cosine_out == last.c && bus.sine_out == last.s), 1);
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_mod_rdy", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end
  initial begin
    bus.tx_en = 0; bus.bb_rdy = 0; bus.I_BB = '0; bus.Q_BB = '0;
    #1 resetn = 0;
    #2 chk_reset("reset");
    repeat (2) @(negedge clk);
    resetn = 1;
    // carrier sweep over all four phases
    step(1);
    repeat (4) step(1, 1, 5, -3);
    step(1);
    chk("busy_run", bus.busy, 1);
    // saturation at phase 1, then sticky across later strobes
    step(1, 1, 0, 0);
    step(1, 1, 2, -16);
    step(1);
    chk("sat_set", bus.sat_flag, 1);
    step(1, 1, 1, 1);
    step(1, 1, -2, 7);
    step(1);
    chk("sat_sticky", bus.sat_flag, 1);
    // gapped and back-to-back strobes
    step(1, 1, 3, 4);
    step(1, 1, -7, 6);
    repeat (3) step(1);
    step(1, 1, 1, -1);
    step(1);
    // bring phase to 2 then stop: two flush strobes return to phase 0
    step(1, 1, -16, 4);
    step(1, 1, 8, -8);
    step(1, 1, -1, 15);
    step(0);
    step(0, 1, 7, 7);
    chk("busy_flush", bus.busy, 1);
    step(0, 1, 7, 7);
    step(0);
    chk("busy_idle", bus.busy, 0);
    chk("sat_after_stop", bus.sat_flag, 1);
    // idle strobes must be ignored
    step(0, 1, 9, 9);
    step(0, 1, 9, 9);
    step(0);
    step(1);
    step(1);
    chk("sat_cleared", bus.sat_flag, 0);
    chk("busy_restart", bus.busy, 1);
    // resume from FLUSH keeps the running phase
    step(1, 1, 1, 2);
    step(1, 1, -4, 3);
    step(0);
    step(0, 1, 4, 4);
    step(1);
    step(1, 1, 6, -2);
    step(1);
    chk("busy_resumed", bus.busy, 1);
    // asynchronous reset between edges drops the in-flight sample
    step(1, 1, 3, 3);
    #2 resetn = 0;
    bus.bb_rdy = 0; bus.tx_en = 0;
    #1 chk_reset("async_reset");
    sb.delete();
    last = '{default: 0};
    m_state = 0; m_phase = PI; m_sat = 0;
    @(negedge clk);
    resetn = 1;
    step(1);
    step(1, 1, 5, -3);
    step(1);
    step(1);
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
